// File: rtl/clock_set_ctrl.sv
// Set-mode controller for the 24-hour clock: edits a shadow hh:mm:ss from key pulses,
// commits it as a day-second load, and drives the display mux and field blink.
module clock_set_ctrl #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_key_mode,
  input  logic        i_key_inc,
  input  logic        i_key_dec,
  input  logic [4:0]  i_cur_hour,
  input  logic [5:0]  i_cur_min,
  input  logic [5:0]  i_cur_sec,
  output logic        o_load_en,
  output logic [16:0] o_load_day,
  output logic [4:0]  o_disp_hour,
  output logic [5:0]  o_disp_min,
  output logic [5:0]  o_disp_sec,
  output logic [1:0]  o_edit_sel,
  output logic        o_blink_on,
  output logic        o_busy
);
  // state    | meaning
  // S_RUN    | clock runs, display follows live time
  // S_SET_H  | editing hour
  // S_SET_M  | editing minute
  // S_SET_S  | editing second
  // S_COMMIT | one-cycle load of the shadow time
  typedef enum logic [2:0] {S_RUN, S_SET_H, S_SET_M, S_SET_S, S_COMMIT} state_t;

  localparam int unsigned IDLE_LIMIT = TIMEOUT_S * CLK_FREQ;
  localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam int unsigned HALF       = (CLK_FREQ / 2 > 0) ? CLK_FREQ / 2 : 1;
  localparam int unsigned BLK_W      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(HALF - 1);

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_sh_h, w_sh_h_nxt;
  logic [5:0]        r_sh_m, w_sh_m_nxt;
  logic [5:0]        r_sh_s, w_sh_s_nxt;
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic [BLK_W-1:0]  r_blk_cnt, w_blk_cnt_nxt;
  logic              r_blink, w_blink_nxt;
  logic              r_load_en;
  logic [16:0]       r_load_day;
  logic              w_set;
  logic              w_edit;
  logic              w_any_key;
  logic [16:0]       w_day;

  assign w_set     = (r_state == S_SET_H) || (r_state == S_SET_M) || (r_state == S_SET_S);
  assign w_any_key = i_key_mode | i_key_inc | i_key_dec;
  // mode has priority; inc+dec together cancel out
  assign w_edit    = w_set && !i_key_mode && (i_key_inc ^ i_key_dec);
  assign w_day     = 17'(r_sh_h) * 17'd3600 + 17'(r_sh_m) * 17'd60 + 17'(r_sh_s);

  always_comb begin
    w_state_nxt   = r_state;
    w_sh_h_nxt    = r_sh_h;
    w_sh_m_nxt    = r_sh_m;
    w_sh_s_nxt    = r_sh_s;
    w_idle_nxt    = '0;
    w_blk_cnt_nxt = '0;
    w_blink_nxt   = 1'b1;

    case (r_state)
      S_RUN: begin
        if (i_key_mode) begin
          w_state_nxt = S_SET_H;
          w_sh_h_nxt  = i_cur_hour;
          w_sh_m_nxt  = i_cur_min;
          w_sh_s_nxt  = i_cur_sec;
        end
      end
      S_SET_H: begin
        if (i_key_mode) w_state_nxt = S_SET_M;
        else if (w_edit) begin
          if (i_key_inc) w_sh_h_nxt = (r_sh_h == 5'd23) ? 5'd0 : r_sh_h + 5'd1;
          else           w_sh_h_nxt = (r_sh_h == 5'd0) ? 5'd23 : r_sh_h - 5'd1;
        end
      end
      S_SET_M: begin
        if (i_key_mode) w_state_nxt = S_SET_S;
        else if (w_edit) begin
          if (i_key_inc) w_sh_m_nxt = (r_sh_m == 6'd59) ? 6'd0 : r_sh_m + 6'd1;
          else           w_sh_m_nxt = (r_sh_m == 6'd0) ? 6'd59 : r_sh_m - 6'd1;
        end
      end
      S_SET_S: begin
        if (i_key_mode) w_state_nxt = S_COMMIT;
        else if (w_edit) begin
          if (i_key_inc) w_sh_s_nxt = (r_sh_s == 6'd59) ? 6'd0 : r_sh_s + 6'd1;
          else           w_sh_s_nxt = (r_sh_s == 6'd0) ? 6'd59 : r_sh_s - 6'd1;
        end
      end
      S_COMMIT: w_state_nxt = S_RUN;
      default:  w_state_nxt = S_RUN;
    endcase

    if (w_set) begin
      if (w_any_key)               w_idle_nxt = '0;
      else if (r_idle == IDLE_LAST) w_state_nxt = S_RUN;
      else                          w_idle_nxt = r_idle + 1'b1;

      if (w_edit) begin
        w_blk_cnt_nxt = '0;
        w_blink_nxt   = 1'b1;
      end else if (r_blk_cnt == BLK_LAST) begin
        w_blk_cnt_nxt = '0;
        w_blink_nxt   = ~r_blink;
      end else begin
        w_blk_cnt_nxt = r_blk_cnt + 1'b1;
        w_blink_nxt   = r_blink;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_RUN;
      r_sh_h     <= '0;
      r_sh_m     <= '0;
      r_sh_s     <= '0;
      r_idle     <= '0;
      r_blk_cnt  <= '0;
      r_blink    <= 1'b1;
      r_load_en  <= 1'b0;
      r_load_day <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sh_h    <= w_sh_h_nxt;
      r_sh_m    <= w_sh_m_nxt;
      r_sh_s    <= w_sh_s_nxt;
      r_idle    <= w_idle_nxt;
      r_blk_cnt <= w_blk_cnt_nxt;
      r_blink   <= w_blink_nxt;
      r_load_en <= (w_state_nxt == S_COMMIT);
      if (w_state_nxt == S_COMMIT) r_load_day <= w_day;
    end
  end

  always_comb begin
    o_edit_sel = 2'd0;
    case (r_state)
      S_SET_H: o_edit_sel = 2'd1;
      S_SET_M: o_edit_sel = 2'd2;
      S_SET_S: o_edit_sel = 2'd3;
      default: o_edit_sel = 2'd0;
    endcase
  end

  assign o_busy      = (r_state != S_RUN);
  assign o_blink_on  = w_set ? r_blink : 1'b1;
  assign o_load_en   = r_load_en;
  assign o_load_day  = r_load_day;
  assign o_disp_hour = (r_state == S_RUN) ? i_cur_hour : r_sh_h;
  assign o_disp_min  = (r_state == S_RUN) ? i_cur_min  : r_sh_m;
  assign o_disp_sec  = (r_state == S_RUN) ? i_cur_sec  : r_sh_s;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus randomized keys, all checked
// every cycle against a time-based behavioural model of the set-mode rules.
module tb_clock_set_ctrl;
  localparam int CF = 10;
  localparam int TO = 2;
  localparam int LIMIT = CF * TO;
  localparam int HALF = CF / 2;

  logic        clk, rstn;
  logic        key_mode, key_inc, key_dec;
  logic [4:0]  cur_hour;
  logic [5:0]  cur_min, cur_sec;
  logic        load_en, blink_on, busy;
  logic [16:0] load_day;
  logic [4:0]  disp_hour;
  logic [5:0]  disp_min, disp_sec;
  logic [1:0]  edit_sel;

  int n_tests = 0;
  int n_fail  = 0;

  clock_set_ctrl #(.CLK_FREQ(CF), .TIMEOUT_S(TO)) dut (
    .clk(clk), .rstn(rstn),
    .i_key_mode(key_mode), .i_key_inc(key_inc), .i_key_dec(key_dec),
    .i_cur_hour(cur_hour), .i_cur_min(cur_min), .i_cur_sec(cur_sec),
    .o_load_en(load_en), .o_load_day(load_day),
    .o_disp_hour(disp_hour), .o_disp_min(disp_min), .o_disp_sec(disp_sec),
    .o_edit_sel(edit_sel), .o_blink_on(blink_on), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: mode 0 run, 1..3 editing field, 4 commit; fields kept as h/m/s integers.
  // idle = cycles since last key in set mode; blk = cycles since blink restart.
  int m_st = 0, m_h = 0, m_m = 0, m_s = 0, m_day = 0, m_idle = 0, m_blk = 0;

  function automatic int wrap(input int v, input int d, input int lim);
    return (v + d + lim) % lim;
  endfunction

  always @(posedge clk or negedge rstn) begin
    int st, h, m, s, day, idle, blk, d;
    if (!rstn) begin
      m_st <= 0; m_h <= 0; m_m <= 0; m_s <= 0; m_day <= 0; m_idle <= 0; m_blk <= 0;
    end else begin
      st = m_st; h = m_h; m = m_m; s = m_s; day = m_day; idle = m_idle; blk = m_blk;
      if (st == 0) begin
        if (key_mode) begin
          st = 1; h = cur_hour; m = cur_min; s = cur_sec; idle = 0; blk = 0;
        end
      end else if (st >= 1 && st <= 3) begin
        if (key_mode) begin
          idle = 0; blk++;
          if (st == 3) begin
            day = h * 3600 + m * 60 + s;
            st = 4;
          end else st++;
        end else if (key_inc || key_dec) begin
          idle = 0;
          if (key_inc != key_dec) begin
            d = key_inc ? 1 : -1;
            if (st == 1)      h = wrap(h, d, 24);
            else if (st == 2) m = wrap(m, d, 60);
            else              s = wrap(s, d, 60);
            blk = 0;
          end else blk++;
        end else if (idle == LIMIT - 1) begin
          st = 0;
        end else begin
          idle++; blk++;
        end
      end else begin
        st = 0;
      end
      m_st <= st; m_h <= h; m_m <= m; m_s <= s; m_day <= day; m_idle <= idle; m_blk <= blk;
    end
  end

  always @(negedge clk) begin
    bit editing;
    editing = (m_st >= 1 && m_st <= 3);
    chk("cmp_load_en", int'(load_en), (m_st == 4) ? 1 : 0);
    chk("cmp_load_day", int'(load_day), m_day);
    chk("cmp_busy", int'(busy), (m_st != 0) ? 1 : 0);
    chk("cmp_edit_sel", int'(edit_sel), editing ? m_st : 0);
    chk("cmp_blink", int'(blink_on), editing ? (((m_blk / HALF) % 2 == 0) ? 1 : 0) : 1);
    chk("cmp_disp_hour", int'(disp_hour), (m_st == 0) ? int'(cur_hour) : m_h);
    chk("cmp_disp_min", int'(disp_min), (m_st == 0) ? int'(cur_min) : m_m);
    chk("cmp_disp_sec", int'(disp_sec), (m_st == 0) ? int'(cur_sec) : m_s);
  end

  task automatic drive(input bit m, input bit i, input bit d);
    key_mode = m; key_inc = i; key_dec = d;
    @(posedge clk); #1;
    key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      drive(0, 0, 0);
    end
  endtask

  initial begin
    int n, r;
    bit km, ki, kd;
    rstn = 1'b1; key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    set_cur(12, 0, 0);
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_load_en", int'(load_en), 0);
    chk("rst_load_day", int'(load_day), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_edit_sel", int'(edit_sel), 0);
    chk("rst_blink", int'(blink_on), 1);
    chk("rst_disp_hour", int'(disp_hour), 12);
    rstn = 1'b1;
    drive(0, 0, 0); drive(0, 0, 0);

    set_cur(10, 20, 30);
    drive(1, 0, 0);
    repeat (3) drive(0, 1, 0);
    drive(1, 0, 0);
    repeat (25) drive(0, 1, 0);
    drive(1, 0, 0);
    chk("set_hour", int'(disp_hour), 13);
    chk("set_min", int'(disp_min), 45);
    chk("set_sec", int'(disp_sec), 30);
    chk("set_edit_sel", int'(edit_sel), 3);
    drive(1, 0, 0);
    chk("commit_load_en", int'(load_en), 1);
    chk("commit_load_day", int'(load_day), 49530);
    chk("commit_edit_sel", int'(edit_sel), 0);
    drive(0, 0, 0);
    chk("after_load_en", int'(load_en), 0);
    chk("after_busy", int'(busy), 0);

    set_cur(23, 0, 59);
    drive(1, 0, 0);
    drive(0, 1, 0); chk("wrap_h_inc", int'(disp_hour), 0);
    drive(0, 0, 1); chk("wrap_h_dec", int'(disp_hour), 23);
    drive(1, 0, 0);
    drive(0, 0, 1); chk("wrap_m_dec", int'(disp_min), 59);
    drive(1, 0, 0);
    drive(0, 1, 0); chk("wrap_s_inc", int'(disp_sec), 0);
    count_busy(n);
    chk("timeout_after_key", n, 20);
    chk("timeout_keeps_day", int'(load_day), 49530);

    drive(1, 0, 0);
    count_busy(n);
    chk("timeout_idle", n, 20);
    drive(1, 0, 0);
    repeat (14) drive(0, 0, 0);
    drive(0, 1, 0);
    count_busy(n);
    chk("timeout_restart", n, 20);

    set_cur(5, 6, 7);
    drive(1, 0, 0);
    drive(0, 1, 1); chk("coll_incdec", int'(disp_hour), 5);
    drive(1, 1, 0);
    chk("coll_mode_sel", int'(edit_sel), 2);
    chk("coll_mode_hour", int'(disp_hour), 5);
    drive(1, 0, 0); drive(1, 0, 0);
    chk("coll_commit_day", int'(load_day), 18367);
    drive(0, 0, 0);
    set_cur(1, 2, 3);
    drive(0, 1, 0);
    chk("run_inc_busy", int'(busy), 0);
    chk("run_inc_hour", int'(disp_hour), 1);

    drive(1, 0, 0);
    chk("blink_entry", int'(blink_on), 1);
    repeat (4) drive(0, 0, 0);
    chk("blink_c4", int'(blink_on), 1);
    drive(0, 0, 0);
    chk("blink_c5", int'(blink_on), 0);
    repeat (5) drive(0, 0, 0);
    chk("blink_c10", int'(blink_on), 1);
    drive(1, 0, 0);
    chk("midset_sel", int'(edit_sel), 2);
    rstn = 1'b0; #1;
    chk("midset_busy", int'(busy), 0);
    chk("midset_load_en", int'(load_en), 0);
    chk("midset_load_day", int'(load_day), 0);
    drive(0, 0, 0);
    rstn = 1'b1;

    for (int k = 0; k < 4000; k++) begin
      case ((k / 500) % 4)
        0: r = 2;
        1: r = 4;
        2: r = 16;
        default: r = 64;
      endcase
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      if ($urandom_range(0, 799) == 0) begin
        rstn = 1'b0;
        drive(0, 0, 0);
        rstn = 1'b1;
      end else begin
        km = ($urandom_range(0, 4 * r - 1) == 0);
        ki = ($urandom_range(0, r - 1) == 0);
        kd = ($urandom_range(0, r - 1) == 0);
        drive(km, ki, kd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
